s3g_packet_rx: RTL and testbench
================================

S3G_PACKET_RX -- requirements
Module: s3g_packet_rx

Interface
REQ-001 SHALL have parameter MAX_PAYLOAD, default 32, the largest accepted payload length in bytes (1..255); sets buffer depth.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, the inter-byte timeout in clk cycles (>=2).
REQ-003 SHALL have parameter START_BYTE, default 8'hD5, the packet start marker.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx_data  input  8  received byte, valid when rx_done=1.
REQ-007 rx_done  input  1  one-cycle strobe per received byte.
REQ-008 packet_done  output  1  one-cycle pulse: packet accepted, CRC good.
REQ-009 packet_error  output  1  one-cycle pulse: packet rejected.
REQ-010 error_code  output  2  reason, valid with packet_error: 1=CRC, 2=overlength, 3=timeout.
REQ-011 busy  output  1  high while not in S_IDLE.
REQ-012 buffer_valid  output  1  buffer holds the last good packet.
REQ-013 payload_len  output  8  length byte of the current/last packet.
REQ-014 buffer_addr  input  8  read address.
REQ-015 buffer_data  output  8  buffer[buffer_addr], registered, 1-cycle latency; 0 for addr>=MAX_PAYLOAD.

Function
REQ-016 SHALL implement states S_IDLE, S_LEN, S_DATA, S_CRC.
REQ-017 S_IDLE: rx_done with rx_data==START_BYTE -> S_LEN, clear buffer_valid, payload_len<=0, write pointer<=0; other bytes ignored.
REQ-018 S_LEN: rx_done -> payload_len<=rx_data, crc<=0; len==0 -> S_CRC; len>MAX_PAYLOAD -> pulse packet_error, error_code=2, -> S_IDLE; else -> S_DATA with byte counter=len.
REQ-019 S_DATA: each rx_done writes rx_data to buffer[ptr], ptr+1, counter-1, crc<=CRC8(crc,rx_data); when counter==1 -> S_CRC.
REQ-020 S_CRC: rx_done -> S_IDLE; rx_data==crc: packet_done=1, buffer_valid<=1; else packet_error=1, error_code=2'd1.
REQ-021 CRC SHALL be CRC-8/MAXIM: poly x^8+x^5+x^4+1, reflected (0x8C), init 0, no final XOR, payload bytes only.
REQ-022 Timeout counter SHALL clear on every rx_done and in S_IDLE, increment otherwise; reaching TIMEOUT_CYCLES-1 outside S_IDLE -> packet_error, error_code=3, -> S_IDLE.
REQ-023 rx_done in the same cycle as timeout expiry SHALL win: byte processed, no timeout.
REQ-024 packet_done/packet_error SHALL assert one cycle after the terminating rx_done (or expiry cycle) and never together.
REQ-025 error_code SHALL hold its value until the next packet_error.
REQ-026 A START_BYTE value received in S_LEN/S_DATA/S_CRC SHALL be treated as data, not a restart.
REQ-027 After an error, buffer_valid SHALL stay 0; buffer contents are partial and unspecified.
REQ-028 Read port SHALL operate in every state; read of an address written the same cycle returns old data.

Reset
REQ-029 rst SHALL force S_IDLE, packet_done=0, packet_error=0, error_code=0, busy=0, buffer_valid=0, payload_len=0, buffer_data=0, crc=0, counters=0.
REQ-030 rst mid-packet SHALL abort silently (no error pulse); buffer RAM is not cleared.

Structure
REQ-031 State encoding, error_code values and the CRC-8/MAXIM next-byte function SHALL live in shared package s3g_pkg.
REQ-032 Buffer SHALL be one sub-module s3g_buf_ram (1 write, 1 registered read port, depth MAX_PAYLOAD).

Verification
REQ-033 D5,01,01,5E -> packet_done one cycle after last byte, payload_len=1, buffer[0]=01, buffer_valid=1.
REQ-034 D5,09,"123456789",A1 -> packet_done; D5,09,"123456789",A0 -> packet_error, error_code=1, buffer_valid=0.
REQ-035 MAX_PAYLOAD=32: D5,21 -> packet_error, error_code=2, back to idle; D5,00,00 -> packet_done, payload_len=0.
REQ-036 TIMEOUT_CYCLES=100: D5,03,AA then idle -> packet_error, error_code=3 100 cycles after AA; byte on expiry cycle -> no error.
REQ-037 rst asserted after D5,05,11 -> busy=0, no pulses; following D5,01,01,5E -> packet_done.
REQ-038 Back-to-back good packets with 0 idle cycles between -> two packet_done pulses, buffer holds second payload.

Source files
------------

// File: rtl/s3g_pkg.sv
// Shared definitions for the S3G packet receiver: FSM states, error codes
// and the CRC-8/MAXIM byte update used on the payload.
package s3g_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LEN  = 2'd1,
    S_DATA = 2'd2,
    S_CRC  = 2'd3
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CRC     = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Reflected polynomial 0x8C (x^8+x^5+x^4+1), shifted LSB first.
  function automatic logic [7:0] crc8_maxim_next(input logic [7:0] crc,
                                                 input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ 8'h8C;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/s3g_buf_ram.sv
// Payload buffer: one write port, one registered read port. Out-of-range
// reads return zero; a read of the address being written returns old data.
module s3g_buf_ram #(
  parameter int DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rd_data_d;
  logic [7:0] rd_data_q;

  // Storage array is deliberately not reset so contents survive an abort.
  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < DEPTH_B)) begin
      mem_q[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  // Read mux with out-of-range addresses forced to zero.
  always_comb begin
    rd_data_d = 8'h00;
    if (rd_addr < DEPTH_B) begin
      rd_data_d = mem_q[rd_addr[AW-1:0]];
    end else begin
      rd_data_d = 8'h00;
    end
  end

  // Registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= 8'h00;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/s3g_packet_rx.sv
// Byte-stream packet receiver: START, LEN, payload, CRC-8/MAXIM, with an
// inter-byte timeout and a readable buffer holding the last good payload.
module s3g_packet_rx
  import s3g_pkg::*;
#(
  parameter int         MAX_PAYLOAD    = 32,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] START_BYTE     = 8'hD5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       packet_done,
  output logic       packet_error,
  output logic [1:0] error_code,
  output logic       busy,
  output logic       buffer_valid,
  output logic [7:0] payload_len,
  input  logic [7:0] buffer_addr,
  output logic [7:0] buffer_data
);

  localparam int          TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  MAX_LEN = 8'(MAX_PAYLOAD);

  state_e      state_q, state_d;
  logic [7:0]  payload_len_q, payload_len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  crc_q, crc_d;
  logic [TW-1:0] to_q, to_d;
  logic        buffer_valid_q, buffer_valid_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  error_code_q, error_code_d;
  logic        busy_q, busy_d;
  logic        wr_en_s;
  logic        timeout_hit_s;

  // A byte arriving on the expiry cycle suppresses the timeout.
  assign timeout_hit_s = (state_q != S_IDLE) && !rx_done && (to_q == TO_LAST);

  // Next-state, datapath and pulse decode.
  always_comb begin
    state_d        = state_q;
    payload_len_d  = payload_len_q;
    cnt_d          = cnt_q;
    ptr_d          = ptr_q;
    crc_d          = crc_q;
    buffer_valid_d = buffer_valid_q;
    done_d         = 1'b0;
    err_d          = 1'b0;
    error_code_d   = error_code_q;
    wr_en_s        = 1'b0;

    if ((state_q == S_IDLE) || rx_done || timeout_hit_s) begin
      to_d = '0;
    end else begin
      to_d = to_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (rx_done && (rx_data == START_BYTE)) begin
          state_d        = S_LEN;
          buffer_valid_d = 1'b0;
          payload_len_d  = 8'h00;
          ptr_d          = 8'h00;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LEN: begin
        if (rx_done) begin
          payload_len_d = rx_data;
          crc_d         = 8'h00;
          if (rx_data == 8'h00) begin
            state_d = S_CRC;
          end else if (rx_data > MAX_LEN) begin
            state_d      = S_IDLE;
            err_d        = 1'b1;
            error_code_d = ERR_LEN;
          end else begin
            state_d = S_DATA;
            cnt_d   = rx_data;
          end
        end else if (timeout_hit_s) begin
          state_d      = S_IDLE;
          err_d        = 1'b1;
          error_code_d = ERR_TIMEOUT;
        end else begin
          state_d = S_LEN;
        end
      end
      S_DATA: begin
        if (rx_done) begin
          wr_en_s = 1'b1;
          ptr_d   = ptr_q + 8'd1;
          cnt_d   = cnt_q - 8'd1;
          crc_d   = crc8_maxim_next(crc_q, rx_data);
          if (cnt_q == 8'd1) begin
            state_d = S_CRC;
          end else begin
            state_d = S_DATA;
          end
        end else if (timeout_hit_s) begin
          state_d      = S_IDLE;
          err_d        = 1'b1;
          error_code_d = ERR_TIMEOUT;
        end else begin
          state_d = S_DATA;
        end
      end
      S_CRC: begin
        if (rx_done) begin
          state_d = S_IDLE;
          if (rx_data == crc_q) begin
            done_d         = 1'b1;
            buffer_valid_d = 1'b1;
          end else begin
            err_d        = 1'b1;
            error_code_d = ERR_CRC;
          end
        end else if (timeout_hit_s) begin
          state_d      = S_IDLE;
          err_d        = 1'b1;
          error_code_d = ERR_TIMEOUT;
        end else begin
          state_d = S_CRC;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts silently without a pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      payload_len_q  <= 8'h00;
      cnt_q          <= 8'h00;
      ptr_q          <= 8'h00;
      crc_q          <= 8'h00;
      to_q           <= '0;
      buffer_valid_q <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      error_code_q   <= ERR_NONE;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      payload_len_q  <= payload_len_d;
      cnt_q          <= cnt_d;
      ptr_q          <= ptr_d;
      crc_q          <= crc_d;
      to_q           <= to_d;
      buffer_valid_q <= buffer_valid_d;
      done_q         <= done_d;
      err_q          <= err_d;
      error_code_q   <= error_code_d;
      busy_q         <= busy_d;
    end
  end

  s3g_buf_ram #(
    .DEPTH(MAX_PAYLOAD)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en_s),
    .wr_addr(ptr_q),
    .wr_data(rx_data),
    .rd_addr(buffer_addr),
    .rd_data(buffer_data)
  );

  assign packet_done  = done_q;
  assign packet_error = err_q;
  assign error_code   = error_code_q;
  assign busy         = busy_q;
  assign buffer_valid = buffer_valid_q;
  assign payload_len  = payload_len_q;

endmodule

// File: tb/tb_s3g_packet_rx.sv
// Directed bench for s3g_packet_rx: expected pulses queued as frames are
// sent, compared by a negedge monitor when packet_done/packet_error fire.
module tb_s3g_packet_rx;

  localparam int  MAXP = 32;
  localparam int  TO   = 100;
  localparam longint T = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [7:0] buffer_addr = 8'h00;
  logic       packet_done, packet_error, busy, buffer_valid;
  logic [1:0] error_code;
  logic [7:0] payload_len, buffer_data;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       done;
    logic [1:0] code;
    logic [7:0] len;
    longint     at;
  } exp_t;

  exp_t       sb[$];
  longint     t_drv;
  logic [7:0] pl [16];

  s3g_packet_rx #(
    .MAX_PAYLOAD(MAXP),
    .TIMEOUT_CYCLES(TO),
    .START_BYTE(8'hD5)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_done(rx_done),
    .packet_done(packet_done), .packet_error(packet_error),
    .error_code(error_code), .busy(busy), .buffer_valid(buffer_valid),
    .payload_len(payload_len), .buffer_addr(buffer_addr),
    .buffer_data(buffer_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial CRC-8/MAXIM reference (reflected, poly 0x8C, init 0).
  function automatic logic [7:0] crc_step(input logic [7:0] crc, input logic [7:0] b);
    logic [7:0] c;
    logic       fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[0] ^ b[i];
      c  = c >> 1;
      if (fb) c = c ^ 8'h8C;
    end
    return c;
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    t_drv   = $time;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_done = 1'b0;
    end
  endtask

  task automatic expect_pulse(input logic done, input logic [1:0] code,
                              input logic [7:0] len, input longint at);
    exp_t e;
    e.done = done; e.code = code; e.len = len; e.at = at;
    sb.push_back(e);
  endtask

  // Sends D5, n, pl[0..n-1], model CRC; no idle cycles after the CRC byte.
  task automatic frame(input int n);
    logic [7:0] c;
    c = 8'h00;
    send(8'hD5);
    send(8'(n));
    for (int i = 0; i < n; i++) begin
      send(pl[i]);
      c = crc_step(c, pl[i]);
    end
    send(c);
    expect_pulse(1'b1, 2'd0, 8'(n), t_drv + T);
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string tag);
    @(negedge clk);
    rx_done     = 1'b0;
    buffer_addr = a;
    @(negedge clk);
    chk(tag, buffer_data, e);
  endtask

  // Scoreboard monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (packet_done === 1'b1 || packet_error === 1'b1)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {62'd0, packet_done, packet_error}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_done", packet_done, e.done);
        chk("pulse_err", packet_error, !e.done);
        if (!e.done) chk("err_code", error_code, e.code);
        chk("pulse_len", payload_len, e.len);
        chk("pulse_time", $time, e.at);
      end
    end
  end

  initial begin
    logic [7:0] c;
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_done", packet_done, 1'b0);
    chk("rst_err", packet_error, 1'b0);
    chk("rst_code", error_code, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", buffer_valid, 1'b0);
    chk("rst_len", payload_len, 8'd0);
    chk("rst_bufdata", buffer_data, 8'd0);
    rst = 1'b0;

    // Noise in idle is ignored, then D5,01,01,5E
    send(8'h00); send(8'h77); idle(2);
    chk("idle_busy", busy, 1'b0);
    send(8'hD5); send(8'h01); send(8'h01); send(8'h5E);
    expect_pulse(1'b1, 2'd0, 8'd1, t_drv + T);
    idle(2);
    chk("p1_valid", buffer_valid, 1'b1);
    chk("p1_len", payload_len, 8'd1);
    rd(8'd0, 8'h01, "p1_buf0");

    // "123456789" with good CRC A1
    send(8'hD5); send(8'h09);
    for (int i = 0; i < 9; i++) send(8'h31 + 8'(i));
    send(8'hA1);
    expect_pulse(1'b1, 2'd0, 8'd9, t_drv + T);
    idle(2);
    rd(8'd0, 8'h31, "p2_buf0");
    rd(8'd8, 8'h39, "p2_buf8");
    rd(8'd40, 8'h00, "oob_read");

    // Same payload with bad CRC A0
    send(8'hD5); send(8'h09);
    for (int i = 0; i < 9; i++) send(8'h31 + 8'(i));
    send(8'hA0);
    expect_pulse(1'b0, 2'd1, 8'd9, t_drv + T);
    idle(2);
    chk("crcerr_valid", buffer_valid, 1'b0);
    chk("crcerr_code", error_code, 2'd1);

    // Overlength
    send(8'hD5); send(8'h21);
    expect_pulse(1'b0, 2'd2, 8'h21, t_drv + T);
    idle(2);
    chk("ovl_busy", busy, 1'b0);

    // Zero-length packet; error_code holds previous value
    send(8'hD5); send(8'h00); send(8'h00);
    expect_pulse(1'b1, 2'd0, 8'd0, t_drv + T);
    idle(2);
    chk("zero_code_hold", error_code, 2'd2);
    chk("zero_valid", buffer_valid, 1'b1);

    // Timeout after AA
    send(8'hD5); send(8'h03); send(8'hAA);
    expect_pulse(1'b0, 2'd3, 8'd3, t_drv + T * (TO + 1));
    idle(TO + 10);
    chk("to_busy", busy, 1'b0);

    // Byte on the expiry cycle wins; D5 inside payload is data
    send(8'hD5); send(8'h03); send(8'hAA);
    idle(TO - 1);
    send(8'hD5); send(8'h3C);
    c = crc_step(crc_step(crc_step(8'h00, 8'hAA), 8'hD5), 8'h3C);
    send(c);
    expect_pulse(1'b1, 2'd0, 8'd3, t_drv + T);
    idle(2);
    rd(8'd1, 8'hD5, "exp_buf1");
    rd(8'd2, 8'h3C, "exp_buf2");

    // Reset mid-packet aborts silently
    send(8'hD5); send(8'h05); send(8'h11);
    idle(1);
    chk("mid_busy", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", buffer_valid, 1'b0);
    rst = 1'b0;
    pl[0] = 8'h01;
    frame(1);
    idle(2);

    // Back-to-back good packets
    pl[0] = 8'h10; pl[1] = 8'h20;
    frame(2);
    pl[0] = 8'h30; pl[1] = 8'h40;
    frame(2);
    idle(3);
    rd(8'd0, 8'h30, "b2b_buf0");
    rd(8'd1, 8'h40, "b2b_buf1");
    chk("b2b_valid", buffer_valid, 1'b1);

    idle(5);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
